// File: rtl/eu_isa_pkg.sv
// EU instruction-set constants, issuer state encoding and opcode helpers.
package eu_isa_pkg;

  localparam logic [7:0] OPC_NOP       = 8'h00;
  localparam logic [7:0] OPC_CONV3X3   = 8'h10;
  localparam logic [7:0] OPC_GEMM      = 8'h11;
  localparam logic [7:0] OPC_POOL2D    = 8'h12;
  localparam logic [7:0] OPC_UNPOOL2D  = 8'h13;
  localparam logic [7:0] OPC_CONCAT_C  = 8'h14;
  localparam logic [7:0] OPC_ACT_QUANT = 8'h15;
  localparam logic [7:0] OPC_END       = 8'hFF;

  localparam int EU_INSN_ARGS = 7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_END_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } issuer_state_e;

  // Compute opcodes carry a header word plus all argument words.
  function automatic logic eu_opc_compute(input logic [7:0] opc);
    return (opc == OPC_CONV3X3) || (opc == OPC_GEMM) || (opc == OPC_POOL2D) ||
           (opc == OPC_UNPOOL2D) || (opc == OPC_CONCAT_C) || (opc == OPC_ACT_QUANT);
  endfunction

  function automatic logic eu_opc_known(input logic [7:0] opc);
    return eu_opc_compute(opc) || (opc == OPC_NOP) || (opc == OPC_END);
  endfunction

  // Unknown opcodes are sent as a lone header word.
  function automatic logic [3:0] eu_insn_words(input logic [7:0] opc);
    return eu_opc_compute(opc) ? 4'd8 : 4'd1;
  endfunction

endpackage

// File: rtl/eu_desc_fifo.sv
// Generic show-ahead synchronous FIFO with occupancy count.
module eu_desc_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy update; clear discards everything including a same-cycle push.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop) count_d = count_q + CW'(1);
      if (!do_push && do_pop) count_d = count_q - CW'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/eu_insn_issuer.sv
// Buffers instruction descriptors and serialises them into the EU word stream.
module eu_insn_issuer
  import eu_isa_pkg::*;
#(
  parameter int INSN_W     = 32,
  parameter int DESC_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear,
  input  logic                            desc_valid,
  output logic                            desc_ready,
  input  logic [7:0]                      desc_opcode,
  input  logic [7:0]                      desc_flags,
  input  logic [EU_INSN_ARGS*INSN_W-1:0]  desc_args,
  output logic                            insn_valid,
  input  logic                            insn_ready,
  output logic [INSN_W-1:0]               insn_data,
  input  logic                            eu_done,
  input  logic                            eu_error_valid,
  output logic                            busy,
  output logic                            halted,
  output logic                            end_sent,
  output logic                            unknown_opc,
  output logic [$clog2(DESC_DEPTH):0]     fifo_count,
  output logic [CNT_W-1:0]                issued_cnt
);
  localparam int DESC_W = 16 + EU_INSN_ARGS * INSN_W;

  issuer_state_e      state_q, state_d;
  logic [DESC_W-1:0]  cur_q, cur_d;
  logic [2:0]         word_idx_q, word_idx_d;
  logic               insn_valid_q, insn_valid_d;
  logic [INSN_W-1:0]  insn_data_q, insn_data_d;
  logic               unknown_q, unknown_d;
  logic [CNT_W-1:0]   issued_q, issued_d;

  logic [DESC_W-1:0]  head;
  logic               fifo_full, fifo_empty, load;
  logic [INSN_W-1:0]  cur_args [8];
  logic [7:0]         cur_opc;
  logic               last_word;

  eu_desc_fifo #(.W(DESC_W), .DEPTH(DESC_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (desc_valid && desc_ready),
    .wdata ({desc_args, desc_flags, desc_opcode}),
    .pop   (load),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Argument words of the descriptor in flight; slot 7 pads the 3-bit index range.
  for (genvar gi = 0; gi < 8; gi++) begin : g_args
    if (gi < EU_INSN_ARGS) begin : g_arg
      assign cur_args[gi] = cur_q[16 + gi*INSN_W +: INSN_W];
    end else begin : g_pad
      assign cur_args[gi] = '0;
    end
  end

  assign cur_opc   = cur_q[7:0];
  assign last_word = ({1'b0, word_idx_q} == (eu_insn_words(cur_opc) - 4'd1));

  // Serialiser next-state: clear beats error, error beats normal issue.
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    word_idx_d   = word_idx_q;
    insn_valid_d = insn_valid_q;
    insn_data_d  = insn_data_q;
    unknown_d    = unknown_q;
    issued_d     = issued_q;
    load         = 1'b0;
    if (clear) begin
      state_d      = ST_IDLE;
      word_idx_d   = '0;
      insn_valid_d = 1'b0;
      unknown_d    = 1'b0;
    end else if (eu_error_valid) begin
      state_d      = ST_HALT;
      insn_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) load = 1'b1;
        end
        ST_SEND: begin
          if (insn_ready) begin
            if (last_word) begin
              issued_d = issued_q + CNT_W'(1);
              if (cur_opc == OPC_END) begin
                state_d      = ST_END_WAIT;
                insn_valid_d = 1'b0;
              end else if (!fifo_empty) begin
                load = 1'b1;
              end else begin
                state_d      = ST_IDLE;
                insn_valid_d = 1'b0;
              end
            end else begin
              word_idx_d  = word_idx_q + 3'd1;
              insn_data_d = cur_args[word_idx_q];
            end
          end
        end
        default: ;
      endcase
      if (load) begin
        state_d      = ST_SEND;
        cur_d        = head;
        word_idx_d   = '0;
        insn_valid_d = 1'b1;
        insn_data_d  = {{(INSN_W-16){1'b0}}, head[15:8], head[7:0]};
        if (!eu_opc_known(head[7:0])) unknown_d = 1'b1;
      end
    end
  end

  // Serialiser registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cur_q        <= '0;
      word_idx_q   <= '0;
      insn_valid_q <= 1'b0;
      insn_data_q  <= '0;
      unknown_q    <= 1'b0;
      issued_q     <= '0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      word_idx_q   <= word_idx_d;
      insn_valid_q <= insn_valid_d;
      insn_data_q  <= insn_data_d;
      unknown_q    <= unknown_d;
      issued_q     <= issued_d;
    end
  end

  // eu_done is status only; completion is tracked by the host.
  logic unused_done;
  assign unused_done = eu_done;

  assign desc_ready  = !fifo_full && (state_q != ST_HALT);
  assign insn_valid  = insn_valid_q;
  assign insn_data   = insn_data_q;
  assign busy        = (state_q != ST_IDLE) || !fifo_empty;
  assign halted      = (state_q == ST_HALT);
  assign end_sent    = (state_q == ST_END_WAIT);
  assign unknown_opc = unknown_q;
  assign issued_cnt  = issued_q;

endmodule

// File: tb/tb_eu_insn_issuer.sv
// Scoreboard bench for eu_insn_issuer: directed scenarios plus randomized traffic.
module tb_eu_insn_issuer;
  import eu_isa_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n, clear, desc_valid, insn_ready, eu_done, eu_error_valid;
  logic         desc_ready, insn_valid, busy, halted, end_sent, unknown_opc;
  logic [7:0]   desc_opcode, desc_flags;
  logic [223:0] desc_args;
  logic [31:0]  insn_data;
  logic [2:0]   fifo_count;
  logic [15:0]  issued_cnt;

  eu_insn_issuer dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_opcode(desc_opcode), .desc_flags(desc_flags), .desc_args(desc_args),
    .insn_valid(insn_valid), .insn_ready(insn_ready), .insn_data(insn_data),
    .eu_done(eu_done), .eu_error_valid(eu_error_valid),
    .busy(busy), .halted(halted), .end_sent(end_sent), .unknown_opc(unknown_opc),
    .fifo_count(fifo_count), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; bit last; } exp_t;
  exp_t        exp_q[$];
  int          vectors = 0;
  int          errors = 0;
  int          model_issued = 0;
  bit          model_unknown = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_data = '0;
  int          ready_mode = 0;   // 0 manual, 1 random, 2 toggle

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference model: what the EU should see for one descriptor.
  task automatic model_push(input logic [7:0] op, input logic [7:0] fl, input logic [223:0] ar);
    bit compute;
    exp_t e;
    compute = (op inside {OPC_CONV3X3, OPC_GEMM, OPC_POOL2D, OPC_UNPOOL2D,
                          OPC_CONCAT_C, OPC_ACT_QUANT});
    if (!compute && op != OPC_NOP && op != OPC_END) model_unknown = 1;
    e.data = {16'h0, fl, op};
    e.last = !compute;
    exp_q.push_back(e);
    if (compute) begin
      for (int i = 0; i < 7; i++) begin
        e.data = ar[i*32 +: 32];
        e.last = (i == 6);
        exp_q.push_back(e);
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge, valid still high.
  task automatic push_desc(input logic [7:0] op, input logic [7:0] fl, input logic [223:0] ar);
    int guard = 0;
    desc_opcode = op; desc_flags = fl; desc_args = ar; desc_valid = 1'b1;
    @(negedge clk);
    while (!desc_ready && guard < 300) begin guard++; @(negedge clk); end
    if (!desc_ready) check("push_timeout", {63'b0, desc_ready}, 64'd1);
    else model_push(op, fl, ar);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 3000) begin g++; @(negedge clk); end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic clear_pulse();
    ready_mode = 0; insn_ready = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    exp_q.delete(); prev_stall = 0; model_unknown = 0;
  endtask

  function automatic logic [223:0] seq_args();
    logic [223:0] a = '0;
    for (int i = 0; i < 7; i++) a[i*32 +: 32] = 32'(8'h11 * (i + 1));
    return a;
  endfunction

  // Monitor: compare each accepted word against the scoreboard, and stall stability.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_stall = 0;
      else begin
        if (prev_stall) begin
          vectors++;
          if (!insn_valid || insn_data !== prev_data) begin
            errors++;
            $display("FAIL stall_hold: got valid=%0b data=%h expected valid=1 data=%h",
                     insn_valid, insn_data, prev_data);
          end
        end
        if (insn_valid && insn_ready) begin
          vectors++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got %h expected no word", insn_data);
          end else begin
            e = exp_q.pop_front();
            if (insn_data !== e.data) begin
              errors++;
              $display("FAIL word: got %h expected %h", insn_data, e.data);
            end
            if (e.last) model_issued++;
          end
        end
        prev_stall = insn_valid && !insn_ready;
        prev_data  = insn_data;
      end
    end
  end

  // insn_ready pattern generator.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 1) insn_ready = 1'($urandom_range(0, 1));
      else if (ready_mode == 2) insn_ready = !insn_ready;
    end
  end

  initial begin
    int cnt;
    bit found;
    logic [7:0] op;
    logic [223:0] ar;
    rst_n = 1'b0; clear = 1'b0; desc_valid = 1'b0; insn_ready = 1'b0;
    eu_done = 1'b0; eu_error_valid = 1'b0;
    desc_opcode = '0; desc_flags = '0; desc_args = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_insn_valid", {63'b0, insn_valid}, 0);
    check("rst_insn_data", 64'(insn_data), 0);
    check("rst_busy", {63'b0, busy}, 0);
    check("rst_flags", {61'b0, halted, end_sent, unknown_opc}, 0);
    check("rst_fifo_count", 64'(fifo_count), 0);
    check("rst_issued", 64'(issued_cnt), 0);
    check("rst_desc_ready", {63'b0, desc_ready}, 1);

    // NOP then END, always ready
    insn_ready = 1'b1;
    push_desc(OPC_NOP, 8'h00, '0);
    push_desc(OPC_END, 8'h00, '0);
    desc_valid = 1'b0;
    drain();
    check("t1_issued", 64'(issued_cnt), 2);
    check("t1_end_sent", {63'b0, end_sent}, 1);
    check("t1_insn_valid", {63'b0, insn_valid}, 0);
    clear_pulse();
    check("t1_clear_end_sent", {63'b0, end_sent}, 0);

    // GEMM with ready toggling
    ready_mode = 2;
    push_desc(OPC_GEMM, 8'h5A, seq_args());
    desc_valid = 1'b0;
    drain();
    ready_mode = 0;
    check("t2_issued", 64'(issued_cnt), 3);

    // Five CONV3X3 back-to-back while EU stalls, then zero-bubble drain
    insn_ready = 1'b0;
    for (int k = 0; k < 5; k++) push_desc(OPC_CONV3X3, 8'(k), {7{32'(k + 32'h100)}});
    desc_valid = 1'b0;
    check("t3_fifo_full_count", 64'(fifo_count), 4);
    check("t3_desc_ready_low", {63'b0, desc_ready}, 0);
    insn_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin @(negedge clk); if (insn_valid) cnt++; end
    check("t3_valid_cycles", 64'(cnt), 40);
    @(negedge clk);
    check("t3_valid_after", {63'b0, insn_valid}, 0);
    check("t3_fifo_empty", 64'(fifo_count), 0);
    @(posedge clk); #1;
    check("t3_issued", 64'(issued_cnt), 64'(model_issued));

    // EU error at word 3 of a GEMM
    insn_ready = 1'b1;
    push_desc(OPC_GEMM, 8'h5A, seq_args());
    desc_valid = 1'b0;
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(posedge clk); #1;
      if (insn_valid && insn_data == 32'h33) found = 1;
    end
    check("t4_reach_word3", {63'b0, found}, 1);
    insn_ready = 1'b0; eu_error_valid = 1'b1;
    @(posedge clk); #1;
    eu_error_valid = 1'b0; prev_stall = 0; exp_q.delete();
    check("t4_halted", {63'b0, halted}, 1);
    check("t4_insn_valid", {63'b0, insn_valid}, 0);
    check("t4_desc_ready", {63'b0, desc_ready}, 0);
    clear_pulse();
    check("t4_clear_halted", {63'b0, halted}, 0);
    check("t4_clear_fifo", 64'(fifo_count), 0);
    check("t4_clear_busy", {63'b0, busy}, 0);
    check("t4_issued_kept", 64'(issued_cnt), 64'(model_issued));

    // Unknown opcode
    insn_ready = 1'b1;
    push_desc(8'hEE, 8'h01, seq_args());
    desc_valid = 1'b0;
    drain();
    check("t5_unknown", {63'b0, unknown_opc}, 1);
    check("t5_issued", 64'(issued_cnt), 64'(model_issued));
    clear_pulse();
    check("t5_clear_unknown", {63'b0, unknown_opc}, 0);

    // Randomized traffic with random EU back-pressure
    ready_mode = 1;
    for (int n = 0; n < 40; n++) begin
      desc_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      case ($urandom_range(0, 8))
        0: op = OPC_NOP;
        1: op = OPC_CONV3X3;
        2: op = OPC_GEMM;
        3: op = OPC_POOL2D;
        4: op = OPC_UNPOOL2D;
        5: op = OPC_CONCAT_C;
        6: op = OPC_ACT_QUANT;
        default: op = 8'h80 + 8'($urandom_range(0, 15));
      endcase
      for (int i = 0; i < 7; i++) ar[i*32 +: 32] = $urandom;
      push_desc(op, 8'($urandom), ar);
    end
    desc_valid = 1'b0;
    drain();
    ready_mode = 0;
    check("rnd_issued", 64'(issued_cnt), 64'(model_issued & 16'hFFFF));
    check("rnd_unknown", {63'b0, unknown_opc}, {63'b0, model_unknown});
    check("rnd_busy", {63'b0, busy}, 0);

    // Async reset mid-CONV3X3
    insn_ready = 1'b1;
    push_desc(OPC_CONV3X3, 8'h07, seq_args());
    desc_valid = 1'b0;
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(posedge clk); #1;
      if (insn_valid && insn_data == 32'h22) found = 1;
    end
    check("t6_reach_word2", {63'b0, found}, 1);
    #2 rst_n = 1'b0;
    exp_q.delete(); prev_stall = 0; model_issued = 0; model_unknown = 0;
    #1;
    check("t6_rst_valid", {63'b0, insn_valid}, 0);
    check("t6_rst_data", 64'(insn_data), 0);
    check("t6_rst_status", {60'b0, busy, halted, end_sent, unknown_opc}, 0);
    check("t6_rst_counts", {45'b0, fifo_count, issued_cnt}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_desc_ready", {63'b0, desc_ready}, 1);
    push_desc(OPC_NOP, 8'h3C, '0);
    desc_valid = 1'b0;
    drain();
    check("t6_issued", 64'(issued_cnt), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
